memory: RTL and testbench
=========================

MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, meaning word-index bits used; depth = 2**ADDR_BITS = 256 words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port addr, input, 32, read address as a word index (not a byte address).
REQ-006 SHALL have port data, output, 32, read data word.
REQ-007 SHALL have port we, input, 1, write enable.
REQ-008 SHALL have port waddr, input, 32, write address as a word index.
REQ-009 SHALL have port wdata, input, 32, write data word.

Function
REQ-010 SHALL hold 256 words of 32 bits in an internal array.
REQ-011 SHALL drive data combinationally from the word at addr[7:0]; zero clock latency, so data follows an addr change within the same delta cycle.
REQ-012 SHALL ignore addr[31:8] and waddr[31:8]; addresses wrap modulo 256 (addr 0x100 reads word 0).
REQ-013 SHALL write wdata into word waddr[7:0] on a rising clk edge when we=1 and reset=0.
REQ-014 SHALL leave all words unchanged on an edge when we=0 and reset=0.
REQ-015 SHALL give read-during-write old-before-new semantics: before the edge, data shows the old word; after the edge, data shows wdata when addr equals waddr.
REQ-016 SHALL never produce X on data after the first reset; every word has a defined value.
REQ-017 SHALL hold this default program image:
- word 0 = 0x20080005 (addi $t0,$0,5)
- word 1 = 0x2009000A (addi $t1,$0,10)
- word 2 = 0x01095020 (add $t2,$t0,$t1)
- word 3 = 0xAC0A0000 (sw $t2,0($0))
- word 4 = 0x8C0B0000 (lw $t3,0($0))
- word 5 = 0x08000000 (j 0)
- words 6..255 = 0x00000000 (nop)
REQ-018 SHALL contain the default image at simulation time 0 via initialization, before any reset.

Reset
REQ-019 SHALL, on a rising clk edge with reset=1, restore all 256 words to the default image of REQ-017.
REQ-020 SHALL give reset priority over write: a write requested on a reset edge is discarded.
REQ-021 SHALL keep data combinational during and after reset; once the reset edge has occurred, data reflects the default image at the current addr.
REQ-022 SHALL apply a reset asserted mid-operation on the next rising edge only; no asynchronous effect.

Verification
REQ-023 SHALL pass sequential read: no reset, we=0, addr stepped 0,1,2,3,4 every 10 ns -> data = 0x20080005, 0x2009000A, 0x01095020, 0xAC0A0000, 0x8C0B0000.
REQ-024 SHALL pass write-then-read: we=1, waddr=7, wdata=0xDEADBEEF for one edge, then addr=7 -> data = 0xDEADBEEF; addr=6 -> data = 0x00000000.
REQ-025 SHALL pass read-during-write: addr=waddr=2, we=1, wdata=0x12345678 -> data = 0x01095020 before the edge and 0x12345678 after it.
REQ-026 SHALL pass reset restore: overwrite word 0 with 0xFFFFFFFF, then one edge with reset=1, addr=0 -> data = 0x20080005.
REQ-027 SHALL pass reset priority: reset=1, we=1, waddr=9, wdata=0xAAAA5555 on the same edge -> word 9 reads 0x00000000.
REQ-028 SHALL pass address wrap: addr=0x00000101 -> data = 0x2009000A; write with waddr=0x000001FF lands in word 255.

Source files
------------

// File: rtl/memory.sv
// 256 x 32 instruction/data word memory with combinational read, synchronous write,
// and a synchronous reset that reloads the built-in program image.
module memory #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           addr,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  we,
    input  logic [31:0]           waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    // Small boot program; everything above word 5 is a nop.
    localparam logic [DATA_WIDTH-1:0] IMAGE [DEPTH] = '{
        0:       DATA_WIDTH'(32'h2008_0005),
        1:       DATA_WIDTH'(32'h2009_000A),
        2:       DATA_WIDTH'(32'h0109_5020),
        3:       DATA_WIDTH'(32'hAC0A_0000),
        4:       DATA_WIDTH'(32'h8C0B_0000),
        5:       DATA_WIDTH'(32'h0800_0000),
        default: '0
    };

    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = IMAGE;

    logic [ADDR_BITS-1:0] raddr_idx;
    logic [ADDR_BITS-1:0] waddr_idx;
    logic                 unused_addr_bits;

    // Upper address bits are deliberately dropped so addresses wrap modulo DEPTH.
    assign raddr_idx        = addr[ADDR_BITS-1:0];
    assign waddr_idx        = waddr[ADDR_BITS-1:0];
    assign unused_addr_bits = ^{addr[31:ADDR_BITS], waddr[31:ADDR_BITS]};

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= IMAGE;
        end else if (we) begin
            mem_q[waddr_idx] <= wdata;
        end
    end

    assign data = mem_q[raddr_idx];

endmodule

// File: tb/tb_memory.sv
// Directed bench for memory: stimulus pushes expected read words into a queue,
// a separate monitor pops and compares them against the combinational read port.
module tb_memory;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q  [$];
    string       name_q [$];
    event        sample_ev;

    memory #(.ADDR_BITS(8), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .data  (data),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: samples the read port 1 ns after each expectation is posted.
    initial begin
        forever begin
            @(sample_ev);
            #1;
            while (exp_q.size() > 0) begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_checks++;
                if (data !== e) begin
                    n_errors++;
                    $display("FAIL %s: data=%08h expected=%08h (t=%0t)", nm, data, e, $time);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        -> sample_ev;
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic edge_then_settle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] IMG [6] = '{32'h2008_0005, 32'h2009_000A, 32'h0109_5020,
                                        32'hAC0A_0000, 32'h8C0B_0000, 32'h0800_0000};

    initial begin
        reset = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        waddr = 32'd0;
        wdata = 32'd0;

        #1;
        check("init_word0", 32'h2008_0005);
        addr = 32'd5;
        check("init_word5", 32'h0800_0000);

        // Sequential read before any reset: image is present from time 0
        for (int i = 0; i < 5; i++) begin
            at_neg();
            addr = i;
            check($sformatf("seq_read_%0d", i), IMG[i]);
        end

        at_neg();
        reset = 1'b1;
        edge_then_settle();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            addr = i;
            check($sformatf("post_reset_%0d", i), IMG[i]);
        end
        addr = 32'd255;
        check("post_reset_255", 32'h0);

        // Write-then-read
        at_neg();
        we = 1'b1; waddr = 32'd7; wdata = 32'hDEAD_BEEF;
        edge_then_settle();
        we = 1'b0;
        addr = 32'd7;
        check("wr_rd_7", 32'hDEAD_BEEF);
        addr = 32'd6;
        check("wr_rd_6", 32'h0);

        // we=0 leaves memory untouched
        at_neg();
        waddr = 32'd0; wdata = 32'h5555_5555; addr = 32'd0;
        edge_then_settle();
        check("no_we_word0", 32'h2008_0005);

        // Read-during-write: old before edge, new after
        at_neg();
        addr = 32'd2; waddr = 32'd2; we = 1'b1; wdata = 32'h1234_5678;
        check("rdw_before", 32'h0109_5020);
        edge_then_settle();
        we = 1'b0;
        check("rdw_after", 32'h1234_5678);

        // Reset restore
        at_neg();
        we = 1'b1; waddr = 32'd0; wdata = 32'hFFFF_FFFF; addr = 32'd0;
        edge_then_settle();
        we = 1'b0;
        check("overwrite_word0", 32'hFFFF_FFFF);
        at_neg();
        reset = 1'b1;
        check("reset_not_async", 32'hFFFF_FFFF);
        edge_then_settle();
        check("reset_restore_during", 32'h2008_0005);
        reset = 1'b0;
        check("reset_restore_word0", 32'h2008_0005);
        addr = 32'd2;
        check("reset_restore_word2", 32'h0109_5020);
        addr = 32'd7;
        check("reset_restore_word7", 32'h0);

        // Reset priority over write
        at_neg();
        reset = 1'b1; we = 1'b1; waddr = 32'd9; wdata = 32'hAAAA_5555; addr = 32'd9;
        edge_then_settle();
        reset = 1'b0; we = 1'b0;
        check("reset_prio_word9", 32'h0);

        // Address wrap
        at_neg();
        addr = 32'h0000_0101;
        check("wrap_read_101", 32'h2009_000A);
        addr = 32'h0000_0100;
        check("wrap_read_100", 32'h2008_0005);
        we = 1'b1; waddr = 32'h0000_01FF; wdata = 32'hCAFE_F00D;
        edge_then_settle();
        we = 1'b0;
        addr = 32'd255;
        check("wrap_write_255", 32'hCAFE_F00D);
        addr = 32'hFFFF_FFFF;
        check("wrap_read_high", 32'hCAFE_F00D);
        addr = 32'd127;
        check("wrap_word127", 32'h0);

        // Drain the scoreboard, bounded
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
